// File: rtl/sar_pkg.sv
// Shared definitions for the SAR comparator responder: cmp codes, FSM states
// and a counter-width helper.
package sar_pkg;

    typedef enum logic [1:0] {
        CMP_LO   = 2'b00,
        CMP_HI   = 2'b01,
        CMP_EQ   = 2'b10,
        CMP_WAIT = 2'b11
    } cmp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQ,
        S_SETTLE,
        S_CMP,
        S_DONE
    } state_e;

    // Bits needed to hold 0..max_count; never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sar_cmp_core.sv
// Combinational tolerance compare of a trial value against the held sample.
// LO means the trial is too high, HI means it is too low, EQ means within TOL.
module sar_cmp_core
    import sar_pkg::*;
#(
    parameter int NOB = 8,
    parameter int TOL = 0
) (
    input  logic [NOB-1:0] value_i,
    input  logic [NOB-1:0] held_i,
    output cmp_e           code_o
);

    localparam logic [NOB:0] TOL_V = (NOB+1)'(TOL);

    logic [NOB:0] diff;
    logic [NOB:0] mag;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        code_o = CMP_EQ;
        // The extra top bit is the borrow: set when value < held.
        diff   = {1'b0, value_i} - {1'b0, held_i};
        mag    = diff[NOB] ? -diff : diff;
        if (mag <= TOL_V) begin
            code_o = CMP_EQ;
        end else if (diff[NOB]) begin
            code_o = CMP_HI;
        end else begin
            code_o = CMP_LO;
        end
    end

endmodule

// File: rtl/sar_cmp_responder.sv
// Comparator/DAC-side model of the SAR front end: captures vin on a sample rising
// edge, then answers each trial value with LO/HI/EQ, or WAIT while acquiring/settling.
module sar_cmp_responder
    import sar_pkg::*;
#(
    parameter int NOB        = 8,
    parameter int TOL        = 0,
    parameter int ACQ_CYC    = 0,
    parameter int SETTLE_CYC = 0,
    parameter int MAX_STEPS  = NOB + 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NOB-1:0] vin,
    input  logic           sample,
    input  logic [NOB-1:0] value,
    output logic [1:0]     cmp,
    output logic [NOB-1:0] held,
    output logic           busy,
    output logic           timeout
);

    localparam int CNT_W  = cnt_width((ACQ_CYC > SETTLE_CYC) ? ACQ_CYC : SETTLE_CYC);
    localparam int STEP_W = cnt_width(MAX_STEPS);

    localparam logic [CNT_W-1:0]  ACQ_LAST    = CNT_W'((ACQ_CYC > 0) ? ACQ_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [STEP_W-1:0] STEP_MAX    = STEP_W'(MAX_STEPS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   steps_q, steps_d, steps_inc;
    cmp_e                cmp_q, cmp_d;
    logic [NOB-1:0]      held_q, held_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;
    logic                sample_q;
    logic [NOB-1:0]      value_q;

    logic                sample_rise;
    logic                value_chg;
    logic                do_cmp;
    logic                do_tmo;
    cmp_e                core_code;

    sar_cmp_core #(
        .NOB (NOB),
        .TOL (TOL)
    ) u_core (
        .value_i (value),
        .held_i  (held_q),
        .code_o  (core_code)
    );

    assign sample_rise = sample & ~sample_q;
    assign value_chg   = (value != value_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        steps_d   = steps_q;
        cmp_d     = cmp_q;
        held_d    = held_q;
        busy_d    = busy_q;
        timeout_d = timeout_q;
        do_cmp    = 1'b0;
        do_tmo    = 1'b0;
        steps_inc = (steps_q < STEP_MAX) ? steps_q + STEP_W'(1) : steps_q;

        if (sample_rise) begin
            // A rising edge restarts the conversion from any state.
            held_d    = vin;
            steps_d   = '0;
            timeout_d = 1'b0;
            busy_d    = 1'b1;
            cnt_d     = '0;
            cmp_d     = CMP_WAIT;
            state_d   = (ACQ_CYC > 0) ? S_ACQ : S_CMP;
        end else begin
            unique case (state_q)
                S_IDLE: cmp_d = CMP_EQ;
                S_ACQ: begin
                    cmp_d = CMP_WAIT;
                    if (cnt_q == ACQ_LAST) begin
                        cnt_d   = '0;
                        state_d = (SETTLE_CYC > 0) ? S_SETTLE : S_CMP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (steps_q >= STEP_MAX) begin
                        do_tmo = 1'b1;
                    end else if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_CMP;
                        do_cmp  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        cmp_d = CMP_WAIT;
                    end
                end
                S_CMP: begin
                    if (value_chg) begin
                        steps_d = steps_inc;
                        if (steps_inc >= STEP_MAX) begin
                            do_tmo = 1'b1;
                        end else if (SETTLE_CYC > 0) begin
                            state_d = S_SETTLE;
                            cnt_d   = '0;
                            cmp_d   = CMP_WAIT;
                        end else begin
                            do_cmp = 1'b1;
                        end
                    end else if (steps_q >= STEP_MAX) begin
                        do_tmo = 1'b1;
                    end else begin
                        do_cmp = 1'b1;
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase

            // Running out of steps outranks whatever the compare would have said.
            if (do_tmo) begin
                timeout_d = 1'b1;
                cmp_d     = CMP_EQ;
                busy_d    = 1'b0;
                state_d   = S_DONE;
            end else if (do_cmp) begin
                cmp_d = core_code;
                if (core_code == CMP_EQ) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            steps_q   <= '0;
            cmp_q     <= CMP_EQ;
            held_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            sample_q  <= 1'b0;
            value_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            steps_q   <= steps_d;
            cmp_q     <= cmp_d;
            held_q    <= held_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            sample_q  <= sample;
            value_q   <= value;
        end
    end

    assign cmp     = cmp_q;
    assign held    = held_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sar_cmp_responder.sv
// Directed bench for sar_cmp_responder: four parameterisations share one stimulus
// stream; expectations go through a scoreboard queue and an 8-bit SAR loop.
module tb_sar_cmp_responder;
    import sar_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample;
    logic [7:0] vin;
    logic [7:0] value;

    logic [1:0] cmp_w     [4];
    logic [7:0] held_w    [4];
    logic       busy_w    [4];
    logic       timeout_w [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];

    always #5 clk = ~clk;

    // u0 default, u1 tolerance 2, u2 acquire 2 / settle 3, u3 four steps max.
    sar_cmp_responder #(.NOB(8)) u0 (
        .clk(clk), .rst(rst), .vin(vin), .sample(sample), .value(value),
        .cmp(cmp_w[0]), .held(held_w[0]), .busy(busy_w[0]), .timeout(timeout_w[0]));
    sar_cmp_responder #(.NOB(8), .TOL(2)) u1 (
        .clk(clk), .rst(rst), .vin(vin), .sample(sample), .value(value),
        .cmp(cmp_w[1]), .held(held_w[1]), .busy(busy_w[1]), .timeout(timeout_w[1]));
    sar_cmp_responder #(.NOB(8), .ACQ_CYC(2), .SETTLE_CYC(3)) u2 (
        .clk(clk), .rst(rst), .vin(vin), .sample(sample), .value(value),
        .cmp(cmp_w[2]), .held(held_w[2]), .busy(busy_w[2]), .timeout(timeout_w[2]));
    sar_cmp_responder #(.NOB(8), .MAX_STEPS(4)) u3 (
        .clk(clk), .rst(rst), .vin(vin), .sample(sample), .value(value),
        .cmp(cmp_w[3]), .held(held_w[3]), .busy(busy_w[3]), .timeout(timeout_w[3]));

    function automatic logic [31:0] pk(input logic [1:0] c, input logic [7:0] h,
                                       input logic b, input logic t);
        return {20'd0, c, h, b, t};
    endfunction

    function automatic logic [31:0] obs(input int d);
        return {20'd0, cmp_w[d], held_w[d], busy_w[d], timeout_w[d]};
    endfunction

    task automatic push(input string tag, input logic [31:0] e);
        sb_t s;
        s.tag = tag;
        s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic pop_check(input logic [31:0] o);
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed %h, nothing expected", o);
            return;
        end
        s = sb_q.pop_front();
        assert (o === s.exp) else begin
            errors++;
            $error("FAIL %s: observed cmp=%b held=%h busy=%b timeout=%b (raw %h), expected cmp=%b held=%h busy=%b timeout=%b (raw %h)",
                   s.tag, o[11:10], o[9:2], o[1], o[0], o,
                   s.exp[11:10], s.exp[9:2], s.exp[1], s.exp[0], s.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expectation, clock one edge, compare DUT d against it.
    task automatic step(input string tag, input int d, input logic [31:0] e);
        push(tag, e);
        tick();
        pop_check(obs(d));
    endtask

    // Bench-side 8-bit SAR controller driving u0; holds its trial on WAIT.
    task automatic sar_convert(input logic [7:0] v);
        logic [7:0] cur;
        logic [1:0] c;
        int         b;
        int         dec;
        bit         done;
        value  = 8'h80;
        vin    = v;
        sample = 1'b1;
        step($sformatf("sar_capture_%h", v), 0, pk(CMP_WAIT, v, 1'b1, 1'b0));
        sample = 1'b0;
        cur  = 8'h00;
        b    = 7;
        dec  = 0;
        done = 1'b0;
        push($sformatf("sar_done_%h", v), 32'd1);
        push($sformatf("sar_result_%h", v), {24'd0, v});
        push($sformatf("sar_decisions_le9_%h", v), 32'd1);
        push($sformatf("sar_no_timeout_%h", v), 32'd0);
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            c = cmp_w[0];
            if (c == CMP_WAIT) continue;
            dec++;
            if (c == CMP_EQ) begin
                done = 1'b1;
            end else begin
                if (c == CMP_HI) cur[b] = 1'b1;
                if (b == 0) begin
                    value = cur;
                end else begin
                    b--;
                    value = cur | (8'h01 << b);
                end
            end
        end
        pop_check({31'd0, done});
        pop_check({24'd0, value});
        pop_check({31'd0, (dec <= 9)});
        pop_check({31'd0, timeout_w[0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        sample = 1'b0;
        vin    = 8'h00;
        value  = 8'h00;
        tick();
        tick();
        rst = 1'b1;

        // Reset state, all configurations.
        step("reset_u0", 0, pk(CMP_EQ, 8'h00, 1'b0, 1'b0));
        for (int d = 1; d < 4; d++) begin
            push($sformatf("reset_u%0d", d), pk(CMP_EQ, 8'h00, 1'b0, 1'b0));
            pop_check(obs(d));
        end

        // Basic capture and decisions.
        vin = 8'h5A; value = 8'h7F; sample = 1'b1;
        step("basic_capture", 0, pk(CMP_WAIT, 8'h5A, 1'b1, 1'b0));
        sample = 1'b0;
        step("basic_lo", 0, pk(CMP_LO, 8'h5A, 1'b1, 1'b0));
        value = 8'h3F;
        step("basic_hi", 0, pk(CMP_HI, 8'h5A, 1'b1, 1'b0));
        value = 8'h5A;
        step("basic_eq", 0, pk(CMP_EQ, 8'h5A, 1'b0, 1'b0));
        step("basic_done_hold", 0, pk(CMP_EQ, 8'h5A, 1'b0, 1'b0));

        // Tolerance 2 around 8'h40.
        vin = 8'h40; value = 8'h42; sample = 1'b1;
        step("tol_capture", 1, pk(CMP_WAIT, 8'h40, 1'b1, 1'b0));
        sample = 1'b0;
        step("tol_42_eq", 1, pk(CMP_EQ, 8'h40, 1'b0, 1'b0));
        value = 8'h43; sample = 1'b1;
        step("tol_recapture", 1, pk(CMP_WAIT, 8'h40, 1'b1, 1'b0));
        sample = 1'b0;
        step("tol_43_lo", 1, pk(CMP_LO, 8'h40, 1'b1, 1'b0));
        value = 8'h3D;
        step("tol_3d_hi", 1, pk(CMP_HI, 8'h40, 1'b1, 1'b0));
        value = 8'h3E;
        step("tol_3e_eq", 1, pk(CMP_EQ, 8'h40, 1'b0, 1'b0));

        // Acquisition 2 + settle 3 cycles, then 3 settle cycles per value change.
        vin = 8'h20; value = 8'h10; sample = 1'b1;
        step("settle_capture", 2, pk(CMP_WAIT, 8'h20, 1'b1, 1'b0));
        sample = 1'b0;
        for (int i = 0; i < 4; i++)
            step($sformatf("settle_start_wait%0d", i), 2, pk(CMP_WAIT, 8'h20, 1'b1, 1'b0));
        step("settle_first_hi", 2, pk(CMP_HI, 8'h20, 1'b1, 1'b0));
        value = 8'h30;
        for (int i = 0; i < 3; i++)
            step($sformatf("settle_chg1_wait%0d", i), 2, pk(CMP_WAIT, 8'h20, 1'b1, 1'b0));
        step("settle_lo", 2, pk(CMP_LO, 8'h20, 1'b1, 1'b0));
        value = 8'h20;
        for (int i = 0; i < 3; i++)
            step($sformatf("settle_chg2_wait%0d", i), 2, pk(CMP_WAIT, 8'h20, 1'b1, 1'b0));
        step("settle_eq", 2, pk(CMP_EQ, 8'h20, 1'b0, 1'b0));

        // Timeout after four value changes.
        vin = 8'h80; value = 8'h00; sample = 1'b1;
        step("tmo_capture", 3, pk(CMP_WAIT, 8'h80, 1'b1, 1'b0));
        sample = 1'b0;
        step("tmo_hi0", 3, pk(CMP_HI, 8'h80, 1'b1, 1'b0));
        value = 8'hFF;
        step("tmo_step1", 3, pk(CMP_LO, 8'h80, 1'b1, 1'b0));
        value = 8'h00;
        step("tmo_step2", 3, pk(CMP_HI, 8'h80, 1'b1, 1'b0));
        value = 8'hFF;
        step("tmo_step3", 3, pk(CMP_LO, 8'h80, 1'b1, 1'b0));
        value = 8'h00;
        step("tmo_step4_timeout", 3, pk(CMP_EQ, 8'h80, 1'b0, 1'b1));
        step("tmo_hold", 3, pk(CMP_EQ, 8'h80, 1'b0, 1'b1));
        vin = 8'h33; value = 8'h33; sample = 1'b1;
        step("tmo_cleared", 3, pk(CMP_WAIT, 8'h33, 1'b1, 1'b0));
        sample = 1'b0;
        step("tmo_new_eq", 3, pk(CMP_EQ, 8'h33, 1'b0, 1'b0));

        // Sample re-rise mid-CMP restarts with steps=0; a held-high sample is ignored.
        vin = 8'h50; value = 8'h10; sample = 1'b1;
        step("rerise_capture", 3, pk(CMP_WAIT, 8'h50, 1'b1, 1'b0));
        sample = 1'b0;
        step("rerise_hi", 3, pk(CMP_HI, 8'h50, 1'b1, 1'b0));
        value = 8'h60;
        step("rerise_s1", 3, pk(CMP_LO, 8'h50, 1'b1, 1'b0));
        value = 8'h10;
        step("rerise_s2", 3, pk(CMP_HI, 8'h50, 1'b1, 1'b0));
        value = 8'h60;
        step("rerise_s3", 3, pk(CMP_LO, 8'h50, 1'b1, 1'b0));
        vin = 8'h11; sample = 1'b1;
        step("rerise_recapture", 3, pk(CMP_WAIT, 8'h11, 1'b1, 1'b0));
        vin = 8'h22;
        step("rerise_level_ignored", 3, pk(CMP_LO, 8'h11, 1'b1, 1'b0));
        sample = 1'b0;
        value = 8'h05;
        step("rerise_new_s1", 3, pk(CMP_HI, 8'h11, 1'b1, 1'b0));
        value = 8'h60;
        step("rerise_new_s2", 3, pk(CMP_LO, 8'h11, 1'b1, 1'b0));
        value = 8'h05;
        step("rerise_new_s3", 3, pk(CMP_HI, 8'h11, 1'b1, 1'b0));

        // Reset asserted while settling.
        vin = 8'h44; value = 8'h44; sample = 1'b1;
        step("rst_capture", 2, pk(CMP_WAIT, 8'h44, 1'b1, 1'b0));
        sample = 1'b0;
        step("rst_acq", 2, pk(CMP_WAIT, 8'h44, 1'b1, 1'b0));
        step("rst_settle", 2, pk(CMP_WAIT, 8'h44, 1'b1, 1'b0));
        rst = 1'b0;
        step("rst_mid_settle", 2, pk(CMP_EQ, 8'h00, 1'b0, 1'b0));
        rst = 1'b1;
        step("rst_release_idle", 2, pk(CMP_EQ, 8'h00, 1'b0, 1'b0));

        // Closed loop with an 8-bit SAR controller.
        sar_convert(8'h00);
        sar_convert(8'h01);
        sar_convert(8'hFE);
        sar_convert(8'hFF);
        sar_convert(8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
